// File: rtl/mov_seq_gen.sv
// Breaks a 64-bit constant into a MOVZ/MOVK sequence, one halfword per op,
// handed to a consumer over a valid/ready channel.
module mov_seq_gen #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [63:0] value,
  input  logic [4:0]  rd,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_movk,
  output logic [1:0]  op_shamt,
  output logic [15:0] op_imm16,
  output logic [4:0]  op_rd,
  output logic        op_last,
  output logic        done,
  output logic [2:0]  op_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_next;
  logic [63:0] val_q;
  logic [4:0]  rd_q;
  logic [3:0]  mask_q;
  logic [1:0]  cur_q;
  logic        first_q;
  logic [2:0]  cnt_q;
  logic        alive_q;
  logic        done_q;
  logic [2:0]  count_q;

  logic [3:0]  mask_in;
  logic [1:0]  first_idx;
  logic [1:0]  next_idx;
  logic        has_higher;
  logic        accept;
  logic        xfer;

  // An all-zero constant still needs one MOVZ so the register is cleared.
  always_comb begin
    mask_in = 4'b1111;
    if (SKIP_ZERO) begin
      for (int k = 0; k < 4; k++) begin
        mask_in[k] = (value[16*k +: 16] != 16'h0000);
      end
      if (value == 64'h0) mask_in = 4'b0001;
    end
  end

  always_comb begin
    first_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask_in[k]) first_idx = 2'(k);
    end
  end

  always_comb begin
    next_idx   = cur_q;
    has_higher = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (k > int'(cur_q) && mask_q[k]) begin
        next_idx   = 2'(k);
        has_higher = 1'b1;
      end
    end
  end

  assign start_ready = alive_q && (state == IDLE);
  assign op_valid    = (state == EMIT);
  assign op_movk     = op_valid && !first_q;
  assign op_shamt    = op_valid ? cur_q : 2'd0;
  assign op_imm16    = op_valid ? val_q[{cur_q, 4'b0000} +: 16] : 16'h0000;
  assign op_rd       = op_valid ? rd_q : 5'd0;
  assign op_last     = op_valid && !has_higher;
  assign done        = done_q;
  assign op_count    = count_q;

  assign accept = start_valid && start_ready;
  assign xfer   = op_valid && op_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EMIT;
      EMIT: if (xfer && op_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // alive_q keeps start_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q   <= 64'h0;
      rd_q    <= 5'd0;
      mask_q  <= 4'b0000;
      cur_q   <= 2'd0;
      first_q <= 1'b0;
      cnt_q   <= 3'd0;
      alive_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 3'd0;
    end else begin
      alive_q <= 1'b1;
      done_q  <= 1'b0;
      if (accept) begin
        val_q   <= value;
        rd_q    <= rd;
        mask_q  <= mask_in;
        cur_q   <= first_idx;
        first_q <= 1'b1;
        cnt_q   <= 3'd0;
      end
      if (xfer) begin
        first_q <= 1'b0;
        cnt_q   <= cnt_q + 3'd1;
        cur_q   <= next_idx;
        if (op_last) begin
          done_q  <= 1'b1;
          count_q <= cnt_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mov_seq_gen.sv
// Directed and random checks of mov_seq_gen for both SKIP_ZERO settings,
// replaying every emitted op through a MOV register model.
module tb_mov_seq_gen;

  logic        clk;
  logic        reset;
  logic        start_valid [2];
  logic        start_ready [2];
  logic [63:0] value       [2];
  logic [4:0]  rd          [2];
  logic        op_valid    [2];
  logic        op_ready    [2];
  logic        op_movk     [2];
  logic [1:0]  op_shamt    [2];
  logic [15:0] op_imm16    [2];
  logic [4:0]  op_rd       [2];
  logic        op_last     [2];
  logic        done        [2];
  logic [2:0]  op_count    [2];

  int errors = 0;
  int checks = 0;

  logic [1:0]  exp_sh [4];
  logic [15:0] exp_im [4];
  int          exp_n;

  typedef struct {
    logic        sel;
    logic [63:0] val;
    logic [4:0]  dst;
    int          stall;
    bit          intrude;
    int          count;
  } vec_t;

  vec_t vecs [7];

  mov_seq_gen #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .start_valid(start_valid[0]), .start_ready(start_ready[0]),
    .value(value[0]), .rd(rd[0]),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .op_movk(op_movk[0]), .op_shamt(op_shamt[0]), .op_imm16(op_imm16[0]),
    .op_rd(op_rd[0]), .op_last(op_last[0]),
    .done(done[0]), .op_count(op_count[0])
  );

  mov_seq_gen #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .start_valid(start_valid[1]), .start_ready(start_ready[1]),
    .value(value[1]), .rd(rd[1]),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .op_movk(op_movk[1]), .op_shamt(op_shamt[1]), .op_imm16(op_imm16[1]),
    .op_rd(op_rd[1]), .op_last(op_last[1]),
    .done(done[1]), .op_count(op_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected op list: ascending halfwords, zero ones dropped when skipping.
  task automatic model(input logic sel, input logic [63:0] v);
    logic [15:0] hw;
    exp_n = 0;
    for (int k = 0; k < 4; k++) begin
      hw = v[16*k +: 16];
      if (!sel || hw != 16'h0) begin
        exp_sh[exp_n] = 2'(k);
        exp_im[exp_n] = hw;
        exp_n++;
      end
    end
    if (exp_n == 0) begin
      exp_sh[0] = 2'd0;
      exp_im[0] = 16'h0;
      exp_n     = 1;
    end
  endtask

  task automatic check_op(input logic sel, input int i, input logic [4:0] r);
    chk("op_valid", 64'(op_valid[sel]), 64'd1);
    chk("op_movk",  64'(op_movk[sel]),  64'(i != 0));
    chk("op_shamt", 64'(op_shamt[sel]), 64'(exp_sh[i]));
    chk("op_imm16", 64'(op_imm16[sel]), 64'(exp_im[i]));
    chk("op_rd",    64'(op_rd[sel]),    64'(r));
    chk("op_last",  64'(op_last[sel]),  64'(i == exp_n - 1));
  endtask

  task automatic wait_ready(input logic sel);
    int w = 0;
    while (!start_ready[sel] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("start_ready_wait", 64'(start_ready[sel]), 64'd1);
  endtask

  task automatic applyStimulus(input logic sel, input logic [63:0] v, input logic [4:0] r,
                               input int stall, input bit intrude, input int count);
    logic [63:0] reg_m;
    int          want;
    model(sel, v);
    want = (count < 0) ? exp_n : count;
    wait_ready(sel);
    start_valid[sel] = 1'b1;
    value[sel]       = v;
    rd[sel]          = r;
    @(posedge clk); #1;
    start_valid[sel] = intrude;
    value[sel]       = ~v;
    rd[sel]          = ~r;
    reg_m = {$urandom, $urandom};
    for (int i = 0; i < exp_n; i++) begin
      op_ready[sel] = 1'b0;
      for (int s = 0; s < ((i == 0) ? stall : 0); s++) begin
        check_op(sel, i, r);
        chk("done_in_stall", 64'(done[sel]), 64'd0);
        @(posedge clk); #1;
      end
      if (i == exp_n - 1) start_valid[sel] = 1'b0;
      op_ready[sel] = 1'b1;
      check_op(sel, i, r);
      if (op_movk[sel]) reg_m[{op_shamt[sel], 4'b0000} +: 16] = op_imm16[sel];
      else              reg_m = 64'(op_imm16[sel]) << {op_shamt[sel], 4'b0000};
      @(posedge clk); #1;
    end
    op_ready[sel] = 1'b0;
    checkOutput(sel, v, reg_m, want);
  endtask

  task automatic checkOutput(input logic sel, input logic [63:0] v,
                             input logic [63:0] reg_m, input int want);
    chk("done_pulse",    64'(done[sel]),        64'd1);
    chk("op_count",      64'(op_count[sel]),    64'(want));
    chk("idle_op_valid", 64'(op_valid[sel]),    64'd0);
    chk("idle_ready",    64'(start_ready[sel]), 64'd1);
    chk("datapath",      reg_m,                 v);
    @(posedge clk); #1;
    chk("done_once",     64'(done[sel]),        64'd0);
    chk("count_hold",    64'(op_count[sel]),    64'(want));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rv;
    vecs[0] = '{1'b1, 64'h0000_0000_0000_0000, 5'd3,  0, 1'b0, 1};
    vecs[1] = '{1'b1, 64'h1234_0000_0000_ABCD, 5'd7,  0, 1'b0, 2};
    vecs[2] = '{1'b1, 64'h0000_5555_0000_0000, 5'd12, 5, 1'b0, 1};
    vecs[3] = '{1'b0, 64'h0001_0002_0003_0004, 5'd21, 0, 1'b1, 4};
    vecs[4] = '{1'b0, 64'h0000_0000_0000_0000, 5'd5,  2, 1'b0, 4};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0001, 5'd31, 1, 1'b0, 2};
    vecs[6] = '{1'b1, 64'hFFFF_0000_FFFF_0000, 5'd0,  0, 1'b1, 2};

    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_valid[s] = 1'b0;
      value[s]       = 64'h0;
      rd[s]          = 5'd0;
      op_ready[s]    = 1'b0;
    end
    #3;
    chk("rst_ready",    64'(start_ready[1]), 64'd0);
    chk("rst_op_valid", 64'(op_valid[1]),    64'd0);
    chk("rst_done",     64'(done[1]),        64'd0);
    chk("rst_count",    64'(op_count[1]),    64'd0);
    #9 reset = 1'b1;
    #1 chk("ready_before_edge", 64'(start_ready[1]), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 64'(start_ready[1]), 64'd1);
    chk("ready_after_edge0", 64'(start_ready[0]), 64'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].val, vecs[i].dst, vecs[i].stall,
                    vecs[i].intrude, vecs[i].count);
    end

    // Reset in the middle of a four-op sequence.
    wait_ready(1'b1);
    start_valid[1] = 1'b1;
    value[1]       = 64'hFFFF_FFFF_FFFF_FFFF;
    rd[1]          = 5'd9;
    @(posedge clk); #1;
    start_valid[1] = 1'b0;
    chk("mid_first_valid", 64'(op_valid[1]), 64'd1);
    chk("mid_first_shamt", 64'(op_shamt[1]), 64'd0);
    op_ready[1] = 1'b1;
    @(posedge clk); #1;
    op_ready[1] = 1'b0;
    chk("mid_second_shamt", 64'(op_shamt[1]), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_op_valid", 64'(op_valid[1]),    64'd0);
    chk("async_ready",    64'(start_ready[1]), 64'd0);
    chk("async_done",     64'(done[1]),        64'd0);
    chk("async_imm",      64'(op_imm16[1]),    64'd0);
    chk("async_count",    64'(op_count[1]),    64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_ready", 64'(start_ready[1]), 64'd1);
      chk("post_rst_valid", 64'(op_valid[1]),    64'd0);
      chk("post_rst_done",  64'(done[1]),        64'd0);
    end
    applyStimulus(1'b1, 64'hDEAD_0000_BEEF_0001, 5'd17, 1, 1'b0, 3);

    for (int n = 0; n < 12; n++) begin
      rv = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0) rv[16*k +: 16] = 16'h0;
      end
      applyStimulus(1'(n % 2), rv, 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
